// File: rtl/fpga_regs_pkg.sv
// Shared constants and helpers for the board-control register bank.
package fpga_regs_pkg;

    localparam int              MSG_W    = 8;
    localparam int              LEN_W    = 8;
    localparam logic [LEN_W-1:0] ECHO_LEN = 8'd1;

    // Counter width able to hold the value plen (at least one bit).
    function automatic int cnt_width(input int plen);
        int w;
        w = $clog2(plen + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fpga_regs_ch_if.sv
// Master byte stream plus per-channel echo handshake of the register bank.
interface fpga_regs_ch_if
    import fpga_regs_pkg::*;
#(
    parameter int N_REGS = 10
);
    logic [MSG_W-1:0]        master_data;
    logic [N_REGS-1:0]       valid_bus;
    logic [N_REGS-1:0]       rdreq_bus;
    logic [N_REGS-1:0]       have_msg_bus;
    logic [N_REGS*MSG_W-1:0] slave_data_bus;
    logic [N_REGS*LEN_W-1:0] len_bus;

    modport master (
        output master_data, valid_bus, rdreq_bus,
        input  have_msg_bus, slave_data_bus, len_bus
    );

    modport slave (
        input  master_data, valid_bus, rdreq_bus,
        output have_msg_bus, slave_data_bus, len_bus
    );
endinterface

// File: rtl/fpga_reg_slot.sv
// One control register: write mask, optional self-clearing pulse, echo holder.
module fpga_reg_slot
    import fpga_regs_pkg::*;
#(
    parameter int            DW         = 8,
    parameter logic [DW-1:0] RST_VAL    = '0,
    parameter logic [DW-1:0] WMASK      = '1,
    parameter bit            PULSE_MODE = 1'b0,
    parameter int            PULSE_LEN  = 16,
    parameter bit            ECHO_EN    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    din_i,
    input  logic             wr_i,
    input  logic             rdreq_i,
    output logic [DW-1:0]    reg_o,
    output logic             pulse_active_o,
    output logic             have_msg_o,
    output logic [MSG_W-1:0] slave_data_o,
    output logic [LEN_W-1:0] len_o
);

    localparam int            CW       = cnt_width(PULSE_LEN);
    localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_LEN);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [DW-1:0]    reg_q,   reg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             act_q,   act_d;
    logic             have_q,  have_d;
    logic [MSG_W-1:0] sdata_q, sdata_d;
    logic [DW-1:0]    wr_val;

    // Read-only bits keep their reset value regardless of the written byte.
    assign wr_val = (din_i & WMASK) | (RST_VAL & ~WMASK);

    // Next state: write/retrigger, pulse countdown to expiry, echo set/pop.
    always_comb begin
        reg_d   = reg_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        have_d  = have_q;
        sdata_d = sdata_q;

        if (wr_i) begin
            reg_d = wr_val;
            if (PULSE_MODE) begin
                cnt_d = CNT_LOAD;
                act_d = 1'b1;
            end
        end else if (PULSE_MODE && act_q) begin
            cnt_d = cnt_q - CNT_ONE;
            // Last counted cycle: value and active flag drop on the same edge.
            if (cnt_q == CNT_ONE) begin
                reg_d = RST_VAL;
                act_d = 1'b0;
            end
        end

        if (ECHO_EN) begin
            // A write beats a simultaneous pop; the older echo is simply replaced.
            if (wr_i) begin
                have_d  = 1'b1;
                sdata_d = MSG_W'(wr_val);
            end else if (rdreq_i && have_q) begin
                have_d = 1'b0;
            end
        end
    end

    // State registers; reset discards pulses and pending echoes.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_q   <= RST_VAL;
            cnt_q   <= '0;
            act_q   <= 1'b0;
            have_q  <= 1'b0;
            sdata_q <= '0;
        end else begin
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            have_q  <= have_d;
            sdata_q <= sdata_d;
        end
    end

    assign reg_o          = reg_q;
    assign pulse_active_o = act_q;
    assign have_msg_o     = have_q;
    assign slave_data_o   = sdata_q;
    assign len_o          = have_q ? ECHO_LEN : '0;

endmodule

// File: rtl/fpga_regs_ch.sv
// Parametrised board-control register bank: N_REGS independent slots.
module fpga_regs_ch
    import fpga_regs_pkg::*;
#(
    parameter int                     N_REGS     = 10,
    parameter int                     DW         = 8,
    parameter logic [N_REGS*DW-1:0]   RST_VAL    = '0,
    parameter logic [N_REGS*DW-1:0]   WMASK      = '1,
    parameter logic [N_REGS-1:0]      PULSE_MASK = '0,
    parameter int                     PULSE_LEN  = 16,
    parameter bit                     ECHO_EN    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    fpga_regs_ch_if.slave        bus,
    output logic [N_REGS*DW-1:0] regs_out,
    output logic [N_REGS-1:0]    pulse_active
);

    logic [N_REGS-1:0]       have_msg;
    logic [N_REGS*MSG_W-1:0] slave_data;
    logic [N_REGS*LEN_W-1:0] len;

    // One slot per channel, each with its own slice of the bank parameters.
    for (genvar i = 0; i < N_REGS; i++) begin : g_slot
        fpga_reg_slot #(
            .DW         (DW),
            .RST_VAL    (RST_VAL[i*DW +: DW]),
            .WMASK      (WMASK[i*DW +: DW]),
            .PULSE_MODE (PULSE_MASK[i]),
            .PULSE_LEN  (PULSE_LEN),
            .ECHO_EN    (ECHO_EN)
        ) u_slot (
            .clk            (clk),
            .rst            (rst),
            .din_i          (bus.master_data[DW-1:0]),
            .wr_i           (bus.valid_bus[i]),
            .rdreq_i        (bus.rdreq_bus[i]),
            .reg_o          (regs_out[i*DW +: DW]),
            .pulse_active_o (pulse_active[i]),
            .have_msg_o     (have_msg[i]),
            .slave_data_o   (slave_data[i*MSG_W +: MSG_W]),
            .len_o          (len[i*LEN_W +: LEN_W])
        );
    end

    assign bus.have_msg_bus   = have_msg;
    assign bus.slave_data_bus = slave_data;
    assign bus.len_bus        = len;

endmodule

// File: tb/tb_fpga_regs_ch.sv
// Scoreboard bench for the register bank: model results queued per cycle.
module tb_fpga_regs_ch;

    localparam int            N    = 10;
    localparam int            DW   = 8;
    localparam int            PL   = 4;
    localparam logic [N*DW-1:0] RSTV = {16'h0000, 8'h01, 56'h0};
    localparam logic [N*DW-1:0] WM   = {{9{8'hFF}}, 8'h0F};
    localparam logic [N-1:0]    PM   = 10'h200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpga_regs_ch_if #(.N_REGS(N)) bus ();
    logic [N*DW-1:0] regs_out;
    logic [N-1:0]    pulse_active;

    fpga_regs_ch #(
        .N_REGS     (N),
        .DW         (DW),
        .RST_VAL    (RSTV),
        .WMASK      (WM),
        .PULSE_MASK (PM),
        .PULSE_LEN  (PL),
        .ECHO_EN    (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .regs_out     (regs_out),
        .pulse_active (pulse_active)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string        tag;
        int           sel;
        logic [127:0] exp;
    } exp_t;
    exp_t sb[$];

    logic [7:0] m_reg  [N];
    int         m_cnt  [N];
    logic       m_have [N];
    logic [7:0] m_sd   [N];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] observe(input int sel);
        case (sel)
            0:       return 128'(regs_out);
            1:       return 128'(pulse_active);
            2:       return 128'(bus.have_msg_bus);
            3:       return 128'(bus.slave_data_bus);
            default: return 128'(bus.len_bus);
        endcase
    endfunction

    // Behavioural model of one clock edge for the whole bank.
    task automatic model_edge(input logic r, input logic [N-1:0] v, input logic [N-1:0] rq,
                              input logic [7:0] d);
        logic [N*DW-1:0] rv, wm;
        logic [7:0]      rvi, wmi, val;
        rv = RSTV;
        wm = WM;
        for (int i = 0; i < N; i++) begin
            rvi = rv[i*8 +: 8];
            wmi = wm[i*8 +: 8];
            if (r) begin
                m_reg[i] = rvi; m_cnt[i] = 0; m_have[i] = 1'b0; m_sd[i] = 8'h00;
            end else if (v[i]) begin
                val = (d & wmi) | (rvi & ~wmi);
                m_reg[i] = val;
                if (PM[i]) m_cnt[i] = PL;
                m_have[i] = 1'b1;
                m_sd[i]   = val;
            end else begin
                if (PM[i] && m_cnt[i] > 0) begin
                    m_cnt[i] = m_cnt[i] - 1;
                    if (m_cnt[i] == 0) m_reg[i] = rvi;
                end
                if (rq[i] && m_have[i]) m_have[i] = 1'b0;
            end
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] v, input logic [N-1:0] rq,
                        input logic [7:0] d);
        logic [N*DW-1:0] e_reg, e_sd, e_len;
        logic [N-1:0]    e_act, e_have;
        exp_t            e;
        rst             = r;
        bus.valid_bus   = v;
        bus.rdreq_bus   = rq;
        bus.master_data = d;
        model_edge(r, v, rq, d);
        for (int i = 0; i < N; i++) begin
            e_reg[i*8 +: 8] = m_reg[i];
            e_sd[i*8 +: 8]  = m_sd[i];
            e_len[i*8 +: 8] = {7'b0, m_have[i]};
            e_act[i]        = (m_cnt[i] != 0);
            e_have[i]       = m_have[i];
        end
        sb.push_back('{"sb_regs",  0, 128'(e_reg)});
        sb.push_back('{"sb_pulse", 1, 128'(e_act)});
        sb.push_back('{"sb_have",  2, 128'(e_have)});
        sb.push_back('{"sb_sdata", 3, 128'(e_sd)});
        sb.push_back('{"sb_len",   4, 128'(e_len)});
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, observe(e.sel), e.exp);
        end
        rst             = 1'b0;
        bus.valid_bus   = '0;
        bus.rdreq_bus   = '0;
        bus.master_data = '0;
    endtask

    initial begin
        int hi;
        rst             = 1'b1;
        bus.valid_bus   = '0;
        bus.rdreq_bus   = '0;
        bus.master_data = '0;

        // Reset state
        step(1'b1, '0, '0, 8'h00);
        step(1'b1, '0, '0, 8'h00);
        chk("rst_ch7", 128'(regs_out[63:56]), 128'h01);
        chk("rst_regs", 128'(regs_out), 128'(RSTV));
        chk("rst_have", 128'(bus.have_msg_bus), 128'h0);
        chk("rst_pulse", 128'(pulse_active), 128'h0);

        // Masked write and echo pop
        step(1'b0, 10'h001, '0, 8'hA5);
        chk("mask_reg0", 128'(regs_out[7:0]), 128'h05);
        chk("mask_have0", 128'(bus.have_msg_bus[0]), 128'h1);
        chk("mask_sd0", 128'(bus.slave_data_bus[7:0]), 128'h05);
        chk("mask_len0", 128'(bus.len_bus[7:0]), 128'h01);
        step(1'b0, '0, 10'h001, 8'h00);
        chk("pop_have0", 128'(bus.have_msg_bus[0]), 128'h0);
        chk("pop_len0", 128'(bus.len_bus[7:0]), 128'h00);
        chk("pop_sd0", 128'(bus.slave_data_bus[7:0]), 128'h05);

        // Pulse on ch9: high for exactly PULSE_LEN cycles
        step(1'b0, 10'h200, '0, 8'h01);
        hi = (regs_out[79:72] == 8'h01) ? 1 : 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, '0, '0, 8'h00);
            if (regs_out[79:72] != 8'h01) break;
            hi++;
        end
        chk("pulse_len", 128'(hi), 128'd4);
        chk("pulse_done", 128'(pulse_active[9]), 128'h0);

        // Retrigger two cycles into the pulse
        step(1'b0, 10'h200, '0, 8'h01);
        hi = (regs_out[79:72] == 8'h01) ? 1 : 0;
        step(1'b0, '0, '0, 8'h00);
        if (regs_out[79:72] == 8'h01) hi++;
        step(1'b0, 10'h200, '0, 8'h01);
        if (regs_out[79:72] == 8'h01) hi++;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, '0, '0, 8'h00);
            if (regs_out[79:72] != 8'h01) break;
            hi++;
        end
        chk("retrig_len", 128'(hi), 128'd6);

        // Write and pop collide on ch4
        step(1'b0, 10'h010, '0, 8'h03);
        chk("coll_pre_sd4", 128'(bus.slave_data_bus[39:32]), 128'h03);
        step(1'b0, 10'h010, 10'h010, 8'h00);
        chk("coll_have4", 128'(bus.have_msg_bus[4]), 128'h1);
        chk("coll_sd4", 128'(bus.slave_data_bus[39:32]), 128'h00);

        // All channels written at once, then popped one by one
        step(1'b0, 10'h3FF, '0, 8'h01);
        chk("multi_have", 128'(bus.have_msg_bus), 128'h3FF);
        chk("multi_regs", 128'(regs_out), 128'({10{8'h01}}));
        for (int i = 0; i < N; i++) begin
            step(1'b0, '0, 10'(1 << i), 8'h00);
            chk("multi_rdreq", 128'(bus.have_msg_bus), 128'(10'(10'h3FF << (i + 1))));
        end

        // Reset in the middle of a pulse with echoes pending
        step(1'b0, 10'h210, '0, 8'h07);
        chk("mid_pulse_on", 128'(pulse_active[9]), 128'h1);
        step(1'b1, '0, '0, 8'h00);
        chk("mid_rst_pulse", 128'(pulse_active), 128'h0);
        chk("mid_rst_regs", 128'(regs_out), 128'(RSTV));
        chk("mid_rst_have", 128'(bus.have_msg_bus), 128'h0);
        step(1'b0, '0, 10'h3FF, 8'h00);
        chk("post_rst_have", 128'(bus.have_msg_bus), 128'h0);
        chk("post_rst_len", 128'(bus.len_bus), 128'h0);

        // Random traffic against the model
        for (int k = 0; k < 60; k++) begin
            step(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
                 10'($urandom_range(0, 1023) & $urandom_range(0, 1023)),
                 10'($urandom_range(0, 1023)),
                 8'($urandom_range(0, 255)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpga_regs_ch.md
Name: fpga_regs_ch

Overview:
Parametrised successor of the board-control register bank. It holds N_REGS independent control registers, each written by its own channel strobe from the master byte stream, and drives static and pulsed control lines to the BOS board (mux address, loads, DAC controls, power-offs, reset/standby).
Unlike the previous bank, each register has a per-bit write mask, a configurable reset value and an optional self-clearing pulse mode. Each channel also echoes every write back to the master through the existing have_msg/rdreq/len slave handshake, so software can confirm each write.

Parameters:
N_REGS, 10, number of register channels
DW, 8, register width in bits (must be <= 8; echo byte is zero-extended)
RST_VAL, {N_REGS*DW{1'b0}}, flat reset/idle value, register i at [i*DW +: DW]
WMASK, {N_REGS*DW{1'b1}}, flat per-bit write-enable mask; 0 = bit is read-only and holds RST_VAL
PULSE_MASK, {N_REGS{1'b0}}, bit i = 1 puts register i in self-clearing pulse mode
PULSE_LEN, 16, pulse duration in clk cycles (>= 1)
ECHO_EN, 1, 1 = writes are echoed on the slave bus; 0 = have_msg_bus tied 0

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
master_data  in  8  write byte, shared by all channels
valid_bus  in  N_REGS  one-cycle write strobe per channel
rdreq_bus  in  N_REGS  master pops the echo of channel i
have_msg_bus  out  N_REGS  echo pending per channel
slave_data_bus  out  N_REGS*8  echo byte per channel
len_bus  out  N_REGS*8  echo length per channel (1 or 0)
regs_out  out  N_REGS*DW  current register values, flat
pulse_active  out  N_REGS  1 while the channel's pulse counter is running

Behaviour:
- Reset (rst=1 at a clk edge) puts outputs in this state on the next cycle:
  - regs_out = RST_VAL.
  - pulse counters = 0, pulse_active = 0.
  - have_msg_bus = 0, slave_data_bus = 0, len_bus = 0.
- Reset has priority over all other inputs, including in-flight pulses and pending echoes; both are discarded.
- Write: valid_bus[i]=1 at edge t updates reg[i] at t+1 (1-cycle latency). The new value is per bit: WMASK bit ? master_data[DW-1:0] bit : RST_VAL bit.
- valid_bus bits are independent. Several channels may be written in the same cycle from the same master_data.
- Pulse mode (PULSE_MASK[i]=1):
  - A write loads cnt[i] = PULSE_LEN and sets pulse_active[i] = 1.
  - cnt[i] decrements once per cycle.
  - On the cycle cnt reaches 0, reg[i] reverts to RST_VAL and pulse_active[i] drops, both visible together.
  - The written value is therefore visible for exactly PULSE_LEN cycles.
  - A write during an active pulse reloads the counter (retrigger) and updates the value.
  - Pulse expiry generates no echo.
- Static mode (PULSE_MASK[i]=0): the value holds until the next write or reset. cnt is unused and pulse_active[i] stays 0.
- Echo (ECHO_EN=1), one-entry holder per channel:
  - A write sets have_msg[i] = 1 at t+1, slave_data[i] = the new masked value zero-extended to 8 bits, and len[i] = 1.
  - rdreq[i]=1 while have_msg[i]=1 clears have_msg[i] and len[i] at the next edge. slave_data[i] keeps the last value.
  - rdreq with have_msg=0 is ignored.
  - Write and rdreq on the same channel in the same cycle: the write wins. have_msg stays 1 with the new data, and the old echo is consumed.
  - A write while an echo is pending overwrites it. Latest value wins; no overflow flag.
- len_bus[i] is always equal to {7'b0, have_msg[i]}.
- No combinational path from any input to any output; every output is registered.

Decomposition:
- Package fpga_regs_pkg holds the constants: MSG_W = 8, LEN_W = 8, ECHO_LEN = 8'd1, and the counter width function clog2(PULSE_LEN+1).
- One natural sub-module, fpga_reg_slot: a single register with its mask, pulse counter and echo holder. It is instantiated N_REGS times in a generate loop with per-slot slices of RST_VAL, WMASK and PULSE_MASK.
- The top level contains only slicing and concatenation.

Test Plan:
- Reset: apply rst=1 for 2 cycles with RST_VAL channel 7 = 8'h01. Required: regs_out ch7 = 1, all other channels 0, have_msg_bus = 0, pulse_active = 0.
- Masked write: WMASK ch0 = 8'h0F, write 8'hA5 to ch0. Required: at t+1, reg0 = 8'h05, have_msg[0] = 1, slave_data ch0 = 8'h05, len ch0 = 1. Then rdreq[0] clears have_msg and len next cycle.
- Pulse with retrigger: PULSE_MASK[9] = 1, PULSE_LEN = 4, write 8'h01 to ch9. Required: reg9 = 1 for exactly 4 cycles, then returns to RST_VAL. Rewriting at cycle 2 extends the high time to 6 cycles total.
- Write and rdreq collision: pending echo 8'h03 on ch4, then valid[4] with 8'h00 and rdreq[4] in the same cycle. Required: have_msg[4] stays 1 and slave_data = 8'h00.
- Multi-channel write: valid_bus = 10'h3FF with master_data = 8'h01. Required: all channels update, all ten have_msg bits set, and each rdreq clears only its own channel.
- Reset mid-operation: rst during an active pulse with a pending echo. Required: next cycle pulse_active = 0, reg = RST_VAL, have_msg = 0. A rdreq right after reset has no effect.
